screen_switch_ctrl: RTL and testbench
=====================================

Name: screen_switch_ctrl

Overview:
Consumer side of the one-hot game-screen select (screen_idle / screen_single / screen_multi) produced by the game-selection FSM. Validates and debounces the requested screen, then performs a frame-aligned, blanked changeover. Drives the 2-bit screen mux select, a display blank, and a one-cycle game-logic reset pulse. Sits between the selection FSM and the video mux / game cores in the 65 MHz pixel domain.

Parameters:
STABLE_CYCLES, 65000, consecutive cycles a request must hold before acceptance (1 ms @ 65 MHz); legal range >= 1
BLANK_FRAMES, 2, full frames the display is blanked before the new mode is applied; legal range >= 1

Ports:
clk65MHz  input  1  pixel clock, sole clock
rst  input  1  synchronous, active-high reset
screen_idle  input  1  idle screen request
screen_single  input  1  singleplayer request
screen_multi  input  1  multiplayer request
vsync_tick  input  1  one-cycle pulse at frame start
mode_sel  output  2  applied mode: 00 idle, 01 single, 10 multi; 11 never driven
blank  output  1  1 = video forced black
game_rst  output  1  one-cycle pulse when a new mode is applied
mode_err  output  1  1 = current input is not one-hot

Behaviour:
- One clock (clk65MHz). Synchronous, active-high reset (rst). All outputs registered.
- Reset: mode_sel=00, blank=0, game_rst=0, mode_err=0, state=SHOW, stability counter=0, frame counter=0, candidate=00, target=00. A reset mid-transition aborts it immediately with these same values.
- Decode, combinational, internal only: exactly one input high -> that mode. Zero or more than one high -> idle (00).
- mode_err: registered. Equals 1 in the cycle after an input sample that is not one-hot. Not sticky.
- Stability filter:
  - Runs in every state.
  - When decoded request != candidate: candidate <= request, counter <= 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
  - stable = (counter == STABLE_CYCLES-1).
  - With STABLE_CYCLES=1, stable is true on the first sample after a change.
- FSM states:
  - SHOW: blank=0. If stable and candidate != mode_sel: target <= candidate, frame counter <= 0, go to FADE. blank=1 from the next cycle.
  - FADE: blank=1. Counts vsync_tick pulses, starting from the cycle after entry; a tick in the entry cycle itself is not counted. On the tick where count == BLANK_FRAMES-1: mode_sel <= target, game_rst <= 1 for exactly that one following cycle, go to SETTLE.
  - SETTLE: blank=1. On the next vsync_tick go to SHOW; blank=0 from the following cycle.
- Requests during FADE/SETTLE: target is frozen and the filter keeps tracking. On return to SHOW, a stable candidate different from mode_sel starts a new transition in the first SHOW cycle.
- A request that reverts to the current mode_sel before becoming stable causes no transition, no blank, no game_rst.
- A transition to the mode already applied is impossible: it is gated by candidate != mode_sel.
- Blank duration per transition, in whole frames: between BLANK_FRAMES and BLANK_FRAMES+1, depending on alignment.
- Counters:
  - Stability counter width: $clog2(STABLE_CYCLES+1).
  - Frame counter width: $clog2(BLANK_FRAMES+1).
  - Neither counter wraps.

Test Plan:
(Bench uses STABLE_CYCLES=4, BLANK_FRAMES=2, vsync_tick every 20 cycles.)
1. Reset, then idle=1 held for 100 cycles -> mode_sel=00, blank=0, game_rst never pulses, mode_err=0.
2. From idle, single=1 (idle=0) held -> blank rises 1 cycle after the 4th stable sample. After the 2nd counted vsync_tick: mode_sel=01 and game_rst high for exactly 1 cycle. blank falls 1 cycle after the next vsync_tick.
3. single=1 pulsed for 3 cycles, then back to idle -> no blank, mode_sel stays 00, no game_rst.
4. single=1 and multi=1 together -> mode_err=1 the next cycle, request decodes to idle. From mode_sel=01 this triggers a transition to 00. Clearing to a legal one-hot drops mode_err after 1 cycle.
5. Request multi (10) held, then switched to single during FADE -> the transition completes to mode_sel=10. After SETTLE->SHOW, a second transition to 01 starts immediately, with exactly one game_rst pulse per transition.
6. Assert rst during FADE -> the next cycle shows blank=0, mode_sel=00, game_rst=0, state SHOW. Resulting vsync_ticks cause no mode change while the input is idle.

Source files
------------

// File: rtl/screen_switch_if.sv
// Request/response bundle between the game-selection FSM and the screen switch controller.
interface screen_switch_if;
  logic       screen_idle;
  logic       screen_single;
  logic       screen_multi;
  logic       vsync_tick;
  logic [1:0] mode_sel;
  logic       blank;
  logic       game_rst;
  logic       mode_err;

  modport master (
    output screen_idle, screen_single, screen_multi, vsync_tick,
    input  mode_sel, blank, game_rst, mode_err
  );

  modport slave (
    input  screen_idle, screen_single, screen_multi, vsync_tick,
    output mode_sel, blank, game_rst, mode_err
  );
endinterface

// File: rtl/screen_switch_ctrl.sv
// Debounces the one-hot screen request and applies it with a frame-aligned,
// blanked changeover, pulsing game_rst when the new mode takes effect.
module screen_switch_ctrl #(
  parameter int STABLE_CYCLES = 65000,
  parameter int BLANK_FRAMES  = 2
) (
  input  logic           clk65MHz,
  input  logic           rst,
  screen_switch_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int FW = $clog2(BLANK_FRAMES + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);

  typedef enum logic [1:0] {SHOW, FADE, SETTLE} state_t;

  state_t        r_state;
  logic [1:0]    r_mode_sel;
  logic          r_blank;
  logic          r_game_rst;
  logic          r_mode_err;
  logic [1:0]    r_cand;
  logic [1:0]    r_target;
  logic [SW-1:0] r_scnt;
  logic [FW-1:0] r_fcnt;

  logic [1:0]    w_req;
  logic          w_onehot;
  logic          w_stable;

  // Anything other than exactly one request line decodes to idle.
  always_comb begin
    w_req    = 2'b00;
    w_onehot = 1'b0;
    case ({bus.screen_multi, bus.screen_single, bus.screen_idle})
      3'b001:  begin w_req = 2'b00; w_onehot = 1'b1; end
      3'b010:  begin w_req = 2'b01; w_onehot = 1'b1; end
      3'b100:  begin w_req = 2'b10; w_onehot = 1'b1; end
      default: begin w_req = 2'b00; w_onehot = 1'b0; end
    endcase
  end

  assign w_stable = (r_scnt == STABLE_MAX);

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_state    <= SHOW;
      r_mode_sel <= 2'b00;
      r_blank    <= 1'b0;
      r_game_rst <= 1'b0;
      r_mode_err <= 1'b0;
      r_cand     <= 2'b00;
      r_target   <= 2'b00;
      r_scnt     <= '0;
      r_fcnt     <= '0;
    end else begin
      r_mode_err <= ~w_onehot;
      r_game_rst <= 1'b0;

      // Filter keeps tracking in every state; target is frozen outside SHOW.
      if (w_req != r_cand) begin
        r_cand <= w_req;
        r_scnt <= '0;
      end else if (r_scnt != STABLE_MAX) begin
        r_scnt <= r_scnt + 1'b1;
      end

      case (r_state)
        SHOW: begin
          r_blank <= 1'b0;
          if (w_stable && (r_cand != r_mode_sel)) begin
            r_target <= r_cand;
            r_fcnt   <= '0;
            r_blank  <= 1'b1;
            r_state  <= FADE;
          end
        end
        FADE: begin
          r_blank <= 1'b1;
          if (bus.vsync_tick) begin
            if (r_fcnt == FRAME_LAST) begin
              r_mode_sel <= r_target;
              r_game_rst <= 1'b1;
              r_state    <= SETTLE;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          r_blank <= 1'b1;
          if (bus.vsync_tick) begin
            r_blank <= 1'b0;
            r_state <= SHOW;
          end
        end
        default: begin
          r_blank <= 1'b0;
          r_state <= SHOW;
        end
      endcase
    end
  end

  assign bus.mode_sel = r_mode_sel;
  assign bus.blank    = r_blank;
  assign bus.game_rst = r_game_rst;
  assign bus.mode_err = r_mode_err;
endmodule

// File: tb/tb_screen_switch_ctrl.sv
// Directed bench for screen_switch_ctrl with a mode scoreboard checked on every game_rst pulse.
module tb_screen_switch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screen_switch_if bus();

  screen_switch_ctrl #(.STABLE_CYCLES(4), .BLANK_FRAMES(2)) dut (
    .clk65MHz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int vcnt = 0;
  int ticks_blank = 0;
  int n_grst = 0;
  logic tick_edge = 1'b0;
  logic prev_grst = 1'b0;
  logic saw_blank, saw_grst, saw_err;
  logic [1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic i, input logic s, input logic m);
    bus.screen_idle   = i;
    bus.screen_single = s;
    bus.screen_multi  = m;
  endtask

  task automatic clr_seen();
    saw_blank = 1'b0;
    saw_grst  = 1'b0;
    saw_err   = 1'b0;
  endtask

  // One clock: observe outputs of the edge just taken, then drive the next vsync sample.
  task automatic step();
    logic b_before;
    logic [1:0] exp_mode;
    b_before  = bus.blank;
    tick_edge = bus.vsync_tick;
    @(posedge clk);
    #1;
    if (b_before && tick_edge) ticks_blank++;
    if (!b_before && bus.blank) ticks_blank = 0;
    if (bus.blank)    saw_blank = 1'b1;
    if (bus.mode_err) saw_err   = 1'b1;
    if (bus.game_rst) begin
      saw_grst = 1'b1;
      n_grst++;
      chk("grst_single_cycle", 32'(prev_grst), 32'(1'b0));
      if (sb.size() == 0) begin
        chk("grst_unexpected", 32'(1'b1), 32'(1'b0));
      end else begin
        exp_mode = sb.pop_front();
        chk("mode_at_grst", 32'(bus.mode_sel), 32'(exp_mode));
        chk("frames_at_grst", 32'(ticks_blank), 32'd2);
      end
    end
    prev_grst = bus.game_rst;
    vcnt = (vcnt == 19) ? 0 : vcnt + 1;
    bus.vsync_tick = (vcnt == 19);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_blank(input logic v, input string tag);
    int n = 0;
    while (bus.blank !== v && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.blank), 32'(v));
  endtask

  task automatic wait_grst(input string tag);
    int n = 0;
    while (bus.game_rst !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.game_rst), 32'(1'b1));
  endtask

  initial begin
    set_req(1'b1, 1'b0, 1'b0);
    bus.vsync_tick = 1'b0;
    clr_seen();

    // Reset state
    steps(3);
    chk("rst_mode", 32'(bus.mode_sel), 32'd0);
    chk("rst_blank", 32'(bus.blank), 32'd0);
    chk("rst_grst", 32'(bus.game_rst), 32'd0);
    chk("rst_err", 32'(bus.mode_err), 32'd0);
    rst = 1'b0;

    // Idle held: nothing happens
    clr_seen();
    steps(100);
    chk("idle_mode", 32'(bus.mode_sel), 32'd0);
    chk("idle_no_blank", 32'(saw_blank), 32'd0);
    chk("idle_no_grst", 32'(saw_grst), 32'd0);
    chk("idle_no_err", 32'(saw_err), 32'd0);

    // Short single glitch, too brief to become stable
    clr_seen();
    set_req(1'b0, 1'b1, 1'b0);
    steps(3);
    set_req(1'b1, 1'b0, 1'b0);
    steps(30);
    chk("glitch_no_blank", 32'(saw_blank), 32'd0);
    chk("glitch_no_grst", 32'(saw_grst), 32'd0);
    chk("glitch_mode", 32'(bus.mode_sel), 32'd0);

    // idle -> single
    set_req(1'b0, 1'b1, 1'b0);
    sb.push_back(2'b01);
    steps(4);
    chk("single_blank_pre", 32'(bus.blank), 32'd0);
    step();
    chk("single_blank_rise", 32'(bus.blank), 32'd1);
    wait_grst("single_grst_seen");
    chk("single_blank_at_grst", 32'(bus.blank), 32'd1);
    step();
    chk("single_grst_width", 32'(bus.game_rst), 32'd0);
    wait_blank(1'b0, "single_blank_fall");
    chk("single_fall_on_tick", 32'(tick_edge), 32'd1);
    chk("single_frames_total", 32'(ticks_blank), 32'd3);
    chk("single_mode", 32'(bus.mode_sel), 32'd1);

    // Illegal request (single+multi) decodes to idle and flags mode_err
    set_req(1'b0, 1'b1, 1'b1);
    sb.push_back(2'b00);
    step();
    chk("err_set", 32'(bus.mode_err), 32'd1);
    wait_grst("err_grst_seen");
    wait_blank(1'b0, "err_blank_fall");
    chk("err_mode", 32'(bus.mode_sel), 32'd0);
    chk("err_still_set", 32'(bus.mode_err), 32'd1);
    set_req(1'b1, 1'b0, 1'b0);
    step();
    chk("err_cleared", 32'(bus.mode_err), 32'd0);

    // multi, then switch to single mid-FADE: two back-to-back transitions
    set_req(1'b0, 1'b0, 1'b1);
    sb.push_back(2'b10);
    wait_blank(1'b1, "multi_blank_rise");
    steps(3);
    set_req(1'b0, 1'b1, 1'b0);
    sb.push_back(2'b01);
    wait_grst("multi_grst_seen");
    wait_blank(1'b0, "multi_blank_fall");
    chk("multi_fall_on_tick", 32'(tick_edge), 32'd1);
    chk("multi_mode", 32'(bus.mode_sel), 32'd2);
    step();
    chk("retrig_blank", 32'(bus.blank), 32'd1);
    wait_grst("retrig_grst_seen");
    wait_blank(1'b0, "retrig_blank_fall");
    chk("retrig_mode", 32'(bus.mode_sel), 32'd1);

    // Reset during FADE aborts the transition
    set_req(1'b0, 1'b0, 1'b1);
    sb.push_back(2'b10);
    wait_blank(1'b1, "abort_blank_rise");
    steps(2);
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0);
    step();
    sb.delete();
    chk("abort_blank", 32'(bus.blank), 32'd0);
    chk("abort_mode", 32'(bus.mode_sel), 32'd0);
    chk("abort_grst", 32'(bus.game_rst), 32'd0);
    rst = 1'b0;
    clr_seen();
    steps(60);
    chk("post_abort_no_blank", 32'(saw_blank), 32'd0);
    chk("post_abort_no_grst", 32'(saw_grst), 32'd0);
    chk("post_abort_mode", 32'(bus.mode_sel), 32'd0);

    chk("grst_total", 32'(n_grst), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
